// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned DefaultW  = 32;
    localparam int unsigned DefaultAW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } state_e;

    localparam logic [31:0] HALT_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [DefaultAW-1:0] pc;
        logic [DefaultW-1:0]  instr;
    } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering fetched {pc, instr} entries.
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 36,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the ROM from address 0 and hands words to execute
// through a valid/ready FIFO, stopping on a halt word or after the last address.
module fetch_unit #(
    parameter int unsigned W     = 32,
    parameter int unsigned AW    = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_i,
    output logic [AW-1:0] rom_addr_o,
    output logic          rom_oe_o,
    input  logic [W-1:0]  rom_data_i,
    output logic [W-1:0]  instr_o,
    output logic [AW-1:0] instr_pc_o,
    output logic          instr_valid_o,
    input  logic          instr_ready_i,
    output logic          busy_o,
    output logic          done_o
);

    import fetch_pkg::*;

    localparam int unsigned EW   = AW + W;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LastPc = '1;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic            push, pop, space, is_halt;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic [EW-1:0]   fifo_rdata;

    assign pop     = ~fifo_empty & instr_ready_i;
    assign space   = ~fifo_full | pop;
    assign is_halt = (rom_data_i == W'(HALT_WORD));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push     = 1'b0;
        rom_oe_o = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                rom_oe_o = 1'b1;
                if (space) begin
                    if (is_halt) begin
                        state_d = StDrain;
                    end else begin
                        push = 1'b1;
                        // Hold pc at the last address so the ROM is never re-read from 0.
                        if (pc_q == LastPc) begin
                            state_d = StDrain;
                        end else begin
                            pc_d = pc_q + AW'(1);
                        end
                    end
                end
            end
            StDrain: begin
                // Leave as soon as the last entry is popped so done follows it directly.
                if (fifo_empty || (fifo_count == CntW'(1) && pop)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_fifo #(
        .Depth (DEPTH),
        .Width (EW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({pc_q, rom_data_i}),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rom_addr_o    = pc_q;
    assign instr_o       = fifo_rdata[W-1:0];
    assign instr_pc_o    = fifo_rdata[EW-1:W];
    assign instr_valid_o = ~fifo_empty;
    assign busy_o        = (state_q == StFetch) || (state_q == StDrain);
    assign done_o        = (state_q == StDone);

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the register-file/ALU calculator datapath. Walks the instruction ROM from address 0 under its own program counter and buffers fetched words with their addresses in a small FIFO. Presents them to the execute stage over a valid/ready handshake, so execute can stall without losing or repeating instructions. Ends the program on a halt word (all zeros) or after the last ROM address.

## Interface
- W, 32, instruction width
- AW, 4, ROM address width (2^AW words)
- DEPTH, 2, FIFO entries (power of two, >= 2)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a program run from address 0; sampled only in IDLE or DONE
- rom_addr  out  AW  ROM address (= pc while fetching)
- rom_oe  out  1  ROM output enable; high only in FETCH
- rom_data  in  W  ROM word, combinational from rom_addr
- instr  out  W  FIFO head instruction
- instr_pc  out  AW  address of instr
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  execute stage consumes head this cycle
- busy  out  1  state is FETCH or DRAIN
- done  out  1  state is DONE

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE: rom_oe=0. If start=1 then pc<=0 and go to FETCH.
- FETCH: rom_oe=1, rom_addr=pc.
  - Space is available when count<DEPTH, or when count==DEPTH and a pop occurs this cycle.
  - If space is available and rom_data==0 (halt word): no push; go to DRAIN.
  - If space is available and rom_data!=0: push {pc, rom_data} and set pc<=pc+1.
    - If pc==2^AW-1: go to DRAIN. pc must not wrap to refetch address 0.
  - If no space is available: no push; pc and rom_addr hold.
- DRAIN: rom_oe=0. Stay in DRAIN until the FIFO is empty, then go to DONE. Pops continue normally.
- DONE: done=1. If start=1 then pc<=0 and go to FETCH.
- start is ignored in FETCH and DRAIN.
- Pop: occurs when instr_valid and instr_ready are both 1. The FIFO advances its head; order is strictly FIFO.
- instr_ready with an empty FIFO has no effect.
- Simultaneous push and pop: count is unchanged, and a push is allowed even when the FIFO is full.
- count range: 0..DEPTH. Read/write pointers wrap modulo DEPTH.
- instr and instr_pc are driven from FIFO storage, not directly from rom_data.
- When the FIFO is empty, instr and instr_pc may hold stale values. They are meaningful only while instr_valid=1.

## Timing
- Reset (asynchronous): state=IDLE, pc=0, count=0, pointers=0.
- Output values during reset: rom_addr=0, rom_oe=0, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0.
- Reset asserted mid-run: the FIFO contents are discarded immediately. There is no drain.
- Start latency: start sampled at edge N → FETCH after edge N → first push at edge N+1 → instr_valid=1 after edge N+1.
- Throughput: one instruction per cycle when instr_ready is held at 1.
- Pop takes effect at the edge where instr_valid and instr_ready are both 1; the new head is visible after that edge.
- Halt detection: the halt word is seen at edge M (state → DRAIN) → busy stays 1 until the FIFO is empty → done=1 the cycle after the last pop.

## Structure
- Package fetch_pkg contains:
  - the state enum {IDLE, FETCH, DRAIN, DONE}
  - HALT_WORD = 32'h0000_0000
  - the entry struct {pc[AW], instr[W]}
- Sub-module fetch_fifo: parameterised by DEPTH and entry width.
  - Ports: push, pop, wdata, rdata, count, full, empty; same clock and asynchronous reset.
  - fetch_unit holds only the FSM and pc.

## Test plan
- ROM = {0x00500093, 0x00308113, 0x002081B3, 0}, instr_ready=1, start pulse → instr_pc 0,1,2 on three consecutive cycles, no entry for address 3, done=1 the cycle after the last pop.
- Same ROM, instr_ready=0 → count reaches 2, rom_addr holds at 2, no further push. Release instr_ready → 0x00500093, 0x00308113, 0x002081B3 delivered in order, none duplicated.
- All 16 ROM words non-zero, instr_ready=1 → exactly 16 instructions with pc 0..15. Enters DRAIN after pc 15; rom_addr never returns to 0 while rom_oe=1.
- FIFO full with instr_ready=1 on the same cycle a non-zero word is fetched → one pop and one push, count stays 2, order preserved.
- start pulsed during FETCH → ignored, the run continues. start pulsed in DONE → new run from address 0, first instr_pc=0.
- reset asserted with 2 entries buffered → instr_valid=0, rom_oe=0, busy=0 immediately. After release, state is IDLE until start.
